// File: rtl/rom_fetch.sv
// rom_fetch: Hack CPU instruction-fetch front end.
// Sequences CPU boot after the ROM loader is ready, issues ROM reads over a
// valid/ready handshake, absorbs the one-cycle SPRAM read latency and returns
// words through a 2-entry response FIFO with flush and out-of-range tagging.
module rom_fetch #(
  parameter int unsigned BOOT_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rom_ready,
  output logic [13:0] rom_address,
  input  logic [15:0] rom_data,
  input  logic        req_valid,
  input  logic [14:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_fault,
  input  logic        resp_ready,
  input  logic        flush,
  output logic        cpu_reset,
  output logic        boot_done
);

  typedef enum logic [1:0] {
    BOOT_WAIT,
    BOOT_DLY,
    RUN
  } state_t;

  localparam logic [3:0] LP_DLY_LAST = 4'(BOOT_DELAY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_cpu_reset;
  logic        r_boot_done;

  logic [13:0] r_rom_addr;
  logic        r_inflight;
  logic        r_tag_fault;

  logic [15:0] r_fifo_data  [2];
  logic        r_fifo_fault [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_run;
  logic        w_pop;
  logic        w_push;
  logic        w_accept;
  logic        w_clear;
  logic [2:0]  w_credit;

  // Handshake, credit and ROM address steering
  always_comb begin
    w_run       = (r_state == RUN);
    resp_valid  = (r_count != 2'd0);
    resp_data   = r_fifo_data[r_rd_ptr];
    resp_fault  = r_fifo_fault[r_rd_ptr];
    w_pop       = resp_valid && resp_ready;
    // Slots already committed (queued + in flight) after this cycle's pop;
    // a pop implies r_count >= 1, so this never underflows.
    w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    req_ready   = w_run && !flush && (w_credit < 3'd2);
    w_accept    = req_valid && req_ready;
    rom_address = w_accept ? req_addr[13:0] : r_rom_addr;
    // Flush and ROM loss both discard queued and in-flight fetches.
    w_clear     = w_run && (flush || !rom_ready);
    w_push      = r_inflight && !w_clear;
    cpu_reset   = r_cpu_reset;
    boot_done   = r_boot_done;
  end

  // Boot sequencer: wait for ROM, settle delay, then release the CPU
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= BOOT_WAIT;
      r_cnt       <= '0;
      r_cpu_reset <= 1'b1;
      r_boot_done <= 1'b0;
    end else begin
      case (r_state)
        BOOT_WAIT: begin
          if (rom_ready) begin
            r_state <= BOOT_DLY;
            r_cnt   <= '0;
          end
        end
        BOOT_DLY: begin
          if (!rom_ready) begin
            r_state <= BOOT_WAIT;
            r_cnt   <= '0;
          end else if (r_cnt == LP_DLY_LAST) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_cpu_reset <= 1'b0;
            r_boot_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RUN: begin
          if (!rom_ready) begin
            r_state     <= BOOT_WAIT;
            r_cpu_reset <= 1'b1;
            r_boot_done <= 1'b0;
          end
        end
        default: begin
          r_state     <= BOOT_WAIT;
          r_cnt       <= '0;
          r_cpu_reset <= 1'b1;
          r_boot_done <= 1'b0;
        end
      endcase
    end
  end

  // Fetch pipeline: in-flight tag, latency absorption and response FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr  <= '0;
      r_inflight  <= 1'b0;
      r_tag_fault <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fifo_data[i]  <= '0;
        r_fifo_fault[i] <= 1'b0;
      end
    end else begin
      if (w_accept) begin
        r_rom_addr <= req_addr[13:0];
      end
      if (w_clear) begin
        r_inflight  <= 1'b0;
        r_tag_fault <= 1'b0;
        r_wr_ptr    <= 1'b0;
        r_rd_ptr    <= 1'b0;
        r_count     <= '0;
      end else begin
        r_inflight <= w_accept;
        if (w_accept) begin
          r_tag_fault <= req_addr[14];
        end
        if (w_push) begin
          r_fifo_data[r_wr_ptr]  <= r_tag_fault ? '0 : rom_data;
          r_fifo_fault[r_wr_ptr] <= r_tag_fault;
          r_wr_ptr               <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  a_fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n) w_push |-> (r_count != 2'd2)
  );

endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed and randomized checks of rom_fetch against a
// transaction-level reference (outstanding-fetch queue, boot streak counter).
module tb_rom_fetch;

  localparam int unsigned BD = 4;

  logic        clk;
  logic        reset_n;
  logic        rom_ready;
  logic [13:0] rom_address;
  logic [15:0] rom_data;
  logic        req_valid;
  logic [14:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_fault;
  logic        resp_ready;
  logic        flush;
  logic        cpu_reset;
  logic        boot_done;

  rom_fetch #(.BOOT_DELAY(BD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rom_ready  (rom_ready),
    .rom_address(rom_address),
    .rom_data   (rom_data),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .resp_ready (resp_ready),
    .flush      (flush),
    .cpu_reset  (cpu_reset),
    .boot_done  (boot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [13:0] a);
    return {2'b00, a} ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] exp_word(input logic [14:0] a);
    return a[14] ? 16'h0000 : mem_word(a[13:0]);
  endfunction

  // SPRAM: one-cycle registered read
  always @(posedge clk) rom_data <= mem_word(rom_address);

  typedef struct {
    int          t;
    logic [14:0] a;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          streak = 0;
  logic [13:0] last_addr = '0;
  logic        dut_acc = 1'b0;
  int          dut_accs = 0;
  int          dut_pops = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic        exp_run;
    logic        exp_valid;
    logic        mpop;
    logic        exp_rdy;
    logic        macc;
    logic [13:0] exp_addr;
    #2;
    exp_run   = reset_n && (streak > int'(BD));
    exp_valid = reset_n && (q.size() > 0) && (q[0].t + 1 < cyc);
    mpop      = exp_valid && resp_ready;
    exp_rdy   = exp_run && !flush && ((q.size() - int'(mpop)) < 2);
    macc      = req_valid && exp_rdy;
    exp_addr  = macc ? req_addr[13:0] : last_addr;
    chk("cpu_reset", 32'(cpu_reset), 32'(!exp_run));
    chk("boot_done", 32'(boot_done), 32'(exp_run));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
    chk("rom_address", 32'(rom_address), 32'(exp_addr));
    if (exp_valid) begin
      chk("resp_data", 32'(resp_data), 32'(exp_word(q[0].a)));
      chk("resp_fault", 32'(resp_fault), 32'(q[0].a[14]));
    end
    dut_acc = req_valid && req_ready;
    if (dut_acc) dut_accs++;
    if (resp_valid && resp_ready) dut_pops++;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      streak    = 0;
      last_addr = '0;
    end else begin
      if (macc) last_addr = req_addr[13:0];
      if (exp_run && (!rom_ready || flush)) begin
        q.delete();
      end else begin
        if (mpop) void'(q.pop_front());
        if (macc) q.push_back('{cyc, req_addr});
      end
      if (!rom_ready) streak = 0;
      else if (streak <= int'(BD)) streak++;
    end
    cyc++;
    #1;
  endtask

  task automatic accept_addr(input logic [14:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    dut_acc   = 1'b0;
    for (int i = 0; i < 20 && !dut_acc; i++) cycle();
    chk("accept_wait", 32'(dut_acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rom_address"}, 32'(rom_address), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_boot_done"}, 32'(boot_done), 32'd0);
  endtask

  task automatic reboot();
    rom_ready = 1'b1;
    repeat (BD + 2) cycle();
    chk("reboot_done", 32'(boot_done), 32'd1);
  endtask

  initial begin
    int n;
    int a0;
    int p0;
    reset_n    = 1'b0;
    rom_ready  = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk_reset_values("por");
    reset_n = 1'b1;

    // Boot: requests pending but must not be accepted before RUN
    req_valid = 1'b1;
    req_addr  = '0;
    while (cyc < 10) cycle();
    rom_ready = 1'b1;
    repeat (BD) cycle();
    chk("boot_still_reset", 32'(cpu_reset), 32'd1);
    cycle();
    chk("boot_released", 32'(cpu_reset), 32'd0);
    chk("boot_done_high", 32'(boot_done), 32'd1);

    // Streaming 0..31 back-to-back
    resp_ready = 1'b1;
    n  = 0;
    p0 = dut_pops;
    repeat (32) begin
      req_addr = 15'(n);
      cycle();
      if (dut_acc) n++;
    end
    req_valid = 1'b0;
    repeat (3) cycle();
    chk("stream_accepts", 32'(n), 32'd32);
    chk("stream_resps", 32'(dut_pops - p0), 32'd32);
    chk("stream_drained", 32'(resp_valid), 32'd0);

    // Back-pressure then release
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    n  = 0;
    a0 = dut_accs;
    repeat (6) begin
      req_addr = 15'(n);
      cycle();
      if (dut_acc) n++;
    end
    chk("bp_accepts", 32'(dut_accs - a0), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    repeat (12) begin
      req_addr = 15'(n);
      cycle();
      if (dut_acc) n++;
    end
    req_valid = 1'b0;
    repeat (3) cycle();
    chk("bp_drained", 32'(resp_valid), 32'd0);

    // Flush discards queued fetches
    resp_ready = 1'b0;
    accept_addr(15'd5);
    accept_addr(15'd6);
    req_valid = 1'b1;
    req_addr  = 15'd7;
    cycle();
    req_valid = 1'b0;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_empty", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;
    p0 = dut_pops;
    accept_addr(15'd100);
    repeat (3) cycle();
    chk("flush_one_resp", 32'(dut_pops - p0), 32'd1);

    // Flush while a fetch is in flight
    accept_addr(15'd200);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (2) cycle();
    chk("flush_inflight", 32'(resp_valid), 32'd0);

    // Out-of-range fetch then in-range fetch
    resp_ready = 1'b0;
    accept_addr(15'h4003);
    cycle();
    chk("fault_data", 32'(resp_data), 32'd0);
    chk("fault_flag", 32'(resp_fault), 32'd1);
    resp_ready = 1'b1;
    accept_addr(15'd3);
    cycle();
    chk("nofault_data", 32'(resp_data), 32'(16'h0003 ^ 16'hA5A5));
    chk("nofault_flag", 32'(resp_fault), 32'd0);
    repeat (2) cycle();

    // ROM loss in RUN
    resp_ready = 1'b0;
    accept_addr(15'd10);
    accept_addr(15'd11);
    cycle();
    rom_ready = 1'b0;
    cycle();
    chk("romloss_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("romloss_fifo_empty", 32'(resp_valid), 32'd0);
    reboot();

    // Asynchronous reset mid-stream, checked before any clock edge
    accept_addr(15'd20);
    accept_addr(15'd21);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values("async");
    q.delete();
    streak    = 0;
    last_addr = '0;
    @(posedge clk);
    cyc++;
    #1;
    cycle();
    reset_n = 1'b1;
    reboot();

    // Randomized traffic
    repeat (400) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = {($urandom_range(0, 7) == 0), 14'($urandom)};
      resp_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      rom_ready  = ($urandom_range(0, 99) != 0);
      cycle();
    end
    flush      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    rom_ready  = 1'b1;
    repeat (BD + 4) cycle();
    chk("final_idle", 32'(resp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
